// File: rtl/pwm_capture_pkg.sv
// Shared level/enable constants and a saturating-add helper for the PWM capture path.
package pwm_capture_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  // Counters stop at the limit instead of wrapping, so a stalled input never aliases a short period.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] lim);
    logic [31:0] sum;
    sum = cnt + inc;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a one-cycle rising-edge strobe
// taken from the synchronized level.
module pwm_sync_edge
  import pwm_capture_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_lvl,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= LOW;
      s2 <= LOW;
      s3 <= LOW;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_lvl = s2;
  assign rise     = s2 & ~s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles and flags
// a stalled input (no rising edge within pTIMEOUT cycles) together with its stuck level.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int pCNT_W   = 12,
  parameter int pTIMEOUT = 4000
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wave_in,
  output logic [pCNT_W-1:0] period,
  output logic [pCNT_W-1:0] high_time,
  output logic              valid,
  output logic              timeout,
  output logic              stuck_lvl
);

  localparam logic [pCNT_W-1:0] LIMIT = pCNT_W'(pTIMEOUT - 1);

  logic              sync_lvl;
  logic              rise;
  logic              active;
  logic              at_limit;
  logic              armed;
  logic [pCNT_W-1:0] per_cnt;
  logic [pCNT_W-1:0] hi_cnt;

  pwm_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (wave_in),
    .sync_lvl (sync_lvl),
    .rise     (rise)
  );

  assign active   = (en == ON);
  assign at_limit = (per_cnt == LIMIT);

  // Both counters restart at 1 on a rise so the rise cycle itself belongs to the new period.
  always_ff @(posedge clk) begin
    if (rst || (en == OFF)) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= pCNT_W'(1);
      hi_cnt  <= pCNT_W'(1);
    end else begin
      per_cnt <= pCNT_W'(sat_add(32'(per_cnt), 32'd1, 32'(pTIMEOUT)));
      hi_cnt  <= pCNT_W'(sat_add(32'(hi_cnt), 32'(sync_lvl == HIGH), 32'(pTIMEOUT)));
    end
  end

  // The first rise after reset, enable or a timeout only opens a measurement window.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      armed <= 1'b0;
    end else if (rise) begin
      armed <= 1'b1;
    end else if (at_limit) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (active && rise && armed) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
        valid     <= 1'b1;
      end
    end
  end

  // A rise in the limit cycle takes priority, so a period of exactly pTIMEOUT-1 still measures.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout   <= 1'b0;
      stuck_lvl <= LOW;
    end else if (active) begin
      if (rise) begin
        timeout <= 1'b0;
      end else if (at_limit) begin
        timeout   <= 1'b1;
        stuck_lvl <= sync_lvl;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: a cycle-indexed reference model predicts
// each measurement from rise times and level history; a monitor pops and compares.
module tb_pwm_capture;

  localparam int W = 12;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         wave_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         stuck_lvl;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
  } meas_t;

  meas_t exp_q[$];

  pwm_capture #(.pCNT_W(W), .pTIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wave_in   (wave_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .stuck_lvl (stuck_lvl)
  );

  always #5 clk = ~clk;

  // Reference model: the logic sees wave_in two edges late; a measurement is the distance
  // between consecutive rises and the count of high samples in between.
  int           cyc = 0;
  logic         h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic         lvl, lvlp;
  bit           lvl_log[$];
  int           last_rise = -1;
  int           ref_cyc = 0;
  int           hi;
  logic         exp_to = 1'b0;
  logic         exp_stuck = 1'b0;
  logic [W-1:0] exp_period = '0;
  logic [W-1:0] exp_high = '0;

  always @(posedge clk) begin : ref_model
    lvl  = h2;
    lvlp = h3;
    lvl_log.push_back(lvl);
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      last_rise  = -1;
      ref_cyc    = cyc + 1;
      exp_to     = 1'b0;
      exp_stuck  = 1'b0;
      exp_period = '0;
      exp_high   = '0;
    end else begin
      h3 = h2; h2 = h1; h1 = wave_in;
      if (!en) begin
        last_rise = -1;
        ref_cyc   = cyc + 1;
      end else if (lvl && !lvlp) begin
        if (last_rise >= 0 && (cyc - last_rise) < T) begin
          hi = 0;
          for (int k = last_rise; k < cyc; k++) hi += int'(lvl_log[k]);
          exp_period = W'(cyc - last_rise);
          exp_high   = W'(hi);
          exp_q.push_back('{period: exp_period, high: exp_high});
        end
        last_rise = cyc;
        ref_cyc   = cyc;
        exp_to    = 1'b0;
      end else if ((cyc - ref_cyc) == T - 1) begin
        exp_to    = 1'b1;
        exp_stuck = lvl;
        last_rise = -1;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin : monitor
    meas_t        m;
    bit           exp_v;
    logic [W-1:0] ep, eh;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() != 0);
      checkOutput("valid", int'(valid), int'(exp_v));
      if (exp_v) begin
        m  = exp_q.pop_front();
        ep = m.period;
        eh = m.high;
      end else begin
        ep = exp_period;
        eh = exp_high;
      end
      checkOutput("period", int'(period), int'(ep));
      checkOutput("high_time", int'(high_time), int'(eh));
      checkOutput("timeout", int'(timeout), int'(exp_to));
      checkOutput("stuck_lvl", int'(stuck_lvl), int'(exp_stuck));
    end
  end

  task automatic applyStimulus(input int high_c, input int low_c, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < high_c; i++) begin
        @(negedge clk);
        wave_in = 1'b1;
      end
      for (int i = 0; i < low_c; i++) begin
        @(negedge clk);
        wave_in = 1'b0;
      end
    end
  endtask

  task automatic pulseControl(input bit do_reset, input int cycles);
    @(negedge clk);
    if (do_reset) rst = 1'b1;
    else en = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin : stimulus
    int hc, lc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    $display("[TB] fixed 4/6 waveform");
    applyStimulus(4, 6, 8);

    $display("[TB] stuck high, then recovery");
    applyStimulus(100, 0, 1);
    applyStimulus(4, 6, 5);

    $display("[TB] stuck low");
    applyStimulus(0, 100, 1);

    $display("[TB] one-cycle pulses and limit-edge periods");
    applyStimulus(1, 4, 6);
    applyStimulus(1, T - 2, 3);
    applyStimulus(1, T - 1, 2);
    applyStimulus(4, 6, 3);

    $display("[TB] reset and enable drop mid-period");
    applyStimulus(2, 0, 1);
    pulseControl(1'b1, 1);
    applyStimulus(2, 6, 1);
    applyStimulus(4, 6, 4);
    applyStimulus(3, 0, 1);
    pulseControl(1'b0, 3);
    applyStimulus(1, 6, 1);
    applyStimulus(4, 6, 4);

    $display("[TB] random waveform");
    for (int p = 0; p < 40; p++) begin
      hc = int'($urandom_range(1, 20));
      lc = int'($urandom_range(1, 20));
      applyStimulus(hc, lc, 1);
      if ($urandom_range(0, 7) == 0) pulseControl(1'b0, int'($urandom_range(1, 4)));
    end

    applyStimulus(0, 10, 1);
    checkOutput("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
